// File: rtl/fetch.sv
// Instruction fetch unit: one outstanding instruction-bus request at a time,
// a 2-entry in-order output FIFO toward the decoder, and redirect handling
// that drops any response belonging to a request issued before the redirect.
module fetch #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr
);

    // IDLE: FIFO full, no request. BUSY: request at req_addr outstanding.
    // DISCARD: request outstanding but its response is stale; refetch from target.
    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDiscard
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [63:0] target_q, target_d;
    logic        ireq_valid_q;

    logic [63:0] pc_q    [2];
    logic [31:0] instr_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q, count_d;

    logic        push;
    logic        pop;
    logic        room;
    logic [63:0] redirect_aligned;
    logic        unused_redirect_lsbs;

    // Low address bits of a redirect are ignored: instructions are word aligned.
    assign redirect_aligned     = {redirect_pc[63:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pop  = (count_q != 2'd0) && !stall;
    // Only a BUSY response is live; DISCARD and IDLE responses never enter the FIFO.
    assign push = (state_q == StBusy) && iresp_data_ok && !redirect_valid;

    // FIFO occupancy for next cycle; a redirect flushes everything.
    always_comb begin
        count_d = count_q;
        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Issue a new request only when the FIFO will have room for its response.
    assign room = (count_d < 2'd2);

    // Next-state, request address and redirect target selection.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        target_d   = target_q;
        if (redirect_valid) begin
            case (state_q)
                StIdle: begin
                    req_addr_d = redirect_aligned;
                    state_d    = StBusy;
                end
                StBusy: begin
                    if (iresp_data_ok) begin
                        // The in-flight request ends now, so the new one can start at once.
                        req_addr_d = redirect_aligned;
                        state_d    = StBusy;
                    end else begin
                        // Keep ireq_addr stable until the stale response arrives.
                        target_d = redirect_aligned;
                        state_d  = StDiscard;
                    end
                end
                default: begin
                    if (iresp_data_ok) begin
                        req_addr_d = redirect_aligned;
                        state_d    = StBusy;
                    end else begin
                        target_d = redirect_aligned;
                    end
                end
            endcase
        end else begin
            case (state_q)
                StIdle: begin
                    if (room) begin
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (iresp_data_ok) begin
                        req_addr_d = req_addr_q + 64'd4;
                        state_d    = room ? StBusy : StIdle;
                    end
                end
                default: begin
                    if (iresp_data_ok) begin
                        req_addr_d = target_q;
                        state_d    = StBusy;
                    end
                end
            endcase
        end
    end

    // Fetch FSM registers, including the registered request-valid output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StBusy;
            req_addr_q   <= PC_RESET;
            target_q     <= 64'd0;
            ireq_valid_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            target_q     <= target_d;
            ireq_valid_q <= (state_d != StIdle);
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q[0]    <= 64'd0;
            pc_q[1]    <= 64'd0;
            instr_q[0] <= 32'd0;
            instr_q[1] <= 32'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                pc_q[wr_ptr_q]    <= req_addr_q;
                instr_q[wr_ptr_q] <= iresp_data;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign ireq_valid = ireq_valid_q;
    assign ireq_addr  = req_addr_q;
    assign out_valid  = (count_q != 2'd0);
    assign out_pc     = pc_q[rd_ptr_q];
    assign out_instr  = instr_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed per-cycle vector table, a randomized scoreboard
// run against a simple instruction-memory responder, and an async-reset check.
module tb_fetch;

    localparam logic [63:0] P = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    int total;
    int bad;

    fetch dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dok;
        logic [31:0] data;
        logic        redir;
        logic [63:0] rpc;
        logic        stl;
        logic        e_iv;
        logic [63:0] e_addr;
        logic        e_ov;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    vec_t   vecs [28];
    entry_t sb [$];

    function automatic vec_t mk(input logic dok, input logic [31:0] data, input logic redir,
                                input logic [63:0] rpc, input logic stl, input logic e_iv,
                                input logic [63:0] e_addr, input logic e_ov,
                                input logic [63:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.dok = dok; v.data = data; v.redir = redir; v.rpc = rpc; v.stl = stl;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_addr;
        entry_t      e;

        total = 0;
        bad   = 0;
        reset          = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        stall          = 1'b0;

        // Inputs applied for one cycle; expectations hold at the start of that cycle.
        //            dok  data          rd   rpc                      st  iv  addr                     ov  pc                       instr
        vecs[0]  = mk(1, 32'h0000_0013, 0, 64'd0,                   1, 1, P,                        0, 64'd0,                   32'd0);
        vecs[1]  = mk(1, 32'h0000_0111, 0, 64'd0,                   1, 1, P + 4,                    1, P,                       32'h13);
        vecs[2]  = mk(1, 32'h0000_dead, 0, 64'd0,                   1, 0, P + 8,                    1, P,                       32'h13);
        vecs[3]  = mk(0, 32'd0,         0, 64'd0,                   0, 0, P + 8,                    1, P,                       32'h13);
        vecs[4]  = mk(1, 32'h0000_0222, 0, 64'd0,                   0, 1, P + 8,                    1, P + 4,                   32'h111);
        vecs[5]  = mk(0, 32'd0,         0, 64'd0,                   0, 1, P + 12,                   1, P + 8,                   32'h222);
        vecs[6]  = mk(0, 32'd0,         1, 64'h8000_1000,           0, 1, P + 12,                   0, 64'd0,                   32'd0);
        vecs[7]  = mk(0, 32'd0,         0, 64'd0,                   0, 1, P + 12,                   0, 64'd0,                   32'd0);
        vecs[8]  = mk(0, 32'd0,         0, 64'd0,                   0, 1, P + 12,                   0, 64'd0,                   32'd0);
        vecs[9]  = mk(1, 32'h0000_0bad, 0, 64'd0,                   0, 1, P + 12,                   0, 64'd0,                   32'd0);
        vecs[10] = mk(1, 32'h0000_0333, 0, 64'd0,                   1, 1, 64'h8000_1000,           0, 64'd0,                   32'd0);
        vecs[11] = mk(1, 32'h0000_0444, 1, 64'h8000_2002,           1, 1, 64'h8000_1004,           1, 64'h8000_1000,           32'h333);
        vecs[12] = mk(0, 32'd0,         1, 64'h100,                 0, 1, 64'h8000_2000,           0, 64'd0,                   32'd0);
        vecs[13] = mk(0, 32'd0,         1, 64'h200,                 0, 1, 64'h8000_2000,           0, 64'd0,                   32'd0);
        vecs[14] = mk(1, 32'h0000_0555, 0, 64'd0,                   0, 1, 64'h8000_2000,           0, 64'd0,                   32'd0);
        vecs[15] = mk(1, 32'h0000_0666, 0, 64'd0,                   0, 1, 64'h200,                 0, 64'd0,                   32'd0);
        vecs[16] = mk(1, 32'h0000_0777, 0, 64'd0,                   0, 1, 64'h204,                 1, 64'h200,                 32'h666);
        vecs[17] = mk(0, 32'd0,         0, 64'd0,                   0, 1, 64'h208,                 1, 64'h204,                 32'h777);
        vecs[18] = mk(1, 32'h0000_0888, 0, 64'd0,                   1, 1, 64'h208,                 0, 64'd0,                   32'd0);
        vecs[19] = mk(1, 32'h0000_0999, 0, 64'd0,                   1, 1, 64'h20c,                 1, 64'h208,                 32'h888);
        vecs[20] = mk(0, 32'd0,         1, 64'h8000_3001,           1, 0, 64'h210,                 1, 64'h208,                 32'h888);
        vecs[21] = mk(0, 32'd0,         1, 64'h400,                 0, 1, 64'h8000_3000,           0, 64'd0,                   32'd0);
        vecs[22] = mk(1, 32'h0000_0eee, 1, 64'h500,                 0, 1, 64'h8000_3000,           0, 64'd0,                   32'd0);
        vecs[23] = mk(0, 32'd0,         1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 64'h500,                 0, 64'd0,                   32'd0);
        vecs[24] = mk(1, 32'h0000_0fff, 0, 64'd0,                   0, 1, 64'h500,                 0, 64'd0,                   32'd0);
        vecs[25] = mk(1, 32'h0000_0aaa, 0, 64'd0,                   0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'd0,                   32'd0);
        vecs[26] = mk(0, 32'd0,         0, 64'd0,                   0, 1, 64'd0,                   1, 64'hFFFF_FFFF_FFFF_FFFC, 32'haaa);
        vecs[27] = mk(0, 32'd0,         0, 64'd0,                   0, 1, 64'd0,                   0, 64'd0,                   32'd0);

        // Reset values while reset is held.
        #12;
        chk("rst_iv", {63'd0, ireq_valid}, 64'd1);
        chk("rst_addr", ireq_addr, P);
        chk("rst_ov", {63'd0, out_valid}, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_instr", {32'd0, out_instr}, 64'd0);
        #8;
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 28; i++) begin
            chk($sformatf("row%0d_iv", i), {63'd0, ireq_valid}, {63'd0, vecs[i].e_iv});
            chk($sformatf("row%0d_addr", i), ireq_addr, vecs[i].e_addr);
            chk($sformatf("row%0d_ov", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            if (vecs[i].e_ov) begin
                chk($sformatf("row%0d_pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("row%0d_instr", i), {32'd0, out_instr}, {32'd0, vecs[i].e_instr});
            end
            iresp_data_ok  = vecs[i].dok;
            iresp_data     = vecs[i].data;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            stall          = vecs[i].stl;
            next_cycle();
        end

        // Random stall/response stream; every completed request is expected in order.
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        exp_addr       = 64'd0;
        for (int c = 0; c < 400; c++) begin
            if (c < 390) begin
                stall         = ($urandom_range(0, 3) == 0);
                iresp_data_ok = $urandom_range(0, 1) == 1;
            end else begin
                stall         = 1'b0;
                iresp_data_ok = 1'b0;
            end
            iresp_data = $urandom;
            chk("sb_ov", {63'd0, out_valid}, {63'd0, (sb.size() != 0)});
            if (ireq_valid) begin
                chk("sb_addr", ireq_addr, exp_addr);
            end
            if (out_valid && !stall) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_pop", out_pc, 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_instr", {32'd0, out_instr}, {32'd0, e.instr});
                end
            end
            if (ireq_valid && iresp_data_ok) begin
                e.pc    = exp_addr;
                e.instr = iresp_data;
                sb.push_back(e);
                exp_addr = exp_addr + 64'd4;
            end
            next_cycle();
        end
        chk("sb_drained", {62'd0, sb.size() == 0, out_valid}, 64'd2);

        // Fill the FIFO, then assert reset between clock edges.
        stall         = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h1234_5678;
        next_cycle();
        next_cycle();
        iresp_data_ok = 1'b0;
        chk("full_ov", {63'd0, out_valid}, 64'd1);
        chk("full_iv", {63'd0, ireq_valid}, 64'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_ov", {63'd0, out_valid}, 64'd0);
        chk("async_iv", {63'd0, ireq_valid}, 64'd1);
        chk("async_addr", ireq_addr, P);
        chk("async_pc", out_pc, 64'd0);
        @(negedge clk);
        reset         = 1'b1;
        stall         = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0abc;
        next_cycle();
        iresp_data_ok = 1'b0;
        chk("post_rst_ov", {63'd0, out_valid}, 64'd1);
        chk("post_rst_pc", out_pc, P);
        chk("post_rst_instr", {32'd0, out_instr}, 64'h abc);
        chk("post_rst_addr", ireq_addr, P + 4);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
